// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the three request/response channels around the unified-memory
//   arbiter: instruction fetch (i_*), data load/store (d_*) and the
//   single-port memory (m_*).
//
//   Modports:
//     slave  - the arbiter: takes fetch/data requests and memory read data,
//              drives grants, read responses and the memory command.
//     master - the surrounding core/memory: drives requests and m_rdata,
//              observes grants, responses and the memory command.
interface mem_arbiter_if #(
    parameter int Width     = 32,
    parameter int AddrWidth = 32
);
    // fetch channel
    logic                 i_req;
    logic [AddrWidth-1:0] i_addr;
    logic                 i_gnt;
    logic                 i_rvalid;
    logic [Width-1:0]     i_rdata;

    // data channel
    logic                 d_req;
    logic                 d_we;
    logic [AddrWidth-1:0] d_addr;
    logic [Width-1:0]     d_wdata;
    logic                 d_gnt;
    logic                 d_rvalid;
    logic [Width-1:0]     d_rdata;

    // unified memory port
    logic                 m_en;
    logic                 m_we;
    logic [AddrWidth-1:0] m_addr;
    logic [Width-1:0]     m_wdata;
    logic [Width-1:0]     m_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port memory between an instruction-fetch port and a
//   data port. At most one access is issued per cycle. Data normally wins,
//   but once fetch has been denied MAX_WAIT cycles in a row it is granted
//   ahead of data so the front end cannot starve. Reads return one cycle
//   after the grant; a new grant may be issued in the same cycle a response
//   is returned, giving one access per cycle throughput.
//
//   Ports:
//     clk    - system clock, rising edge
//     reset  - asynchronous active-low reset, released synchronously
//     bus    - mem_arbiter_if.slave: fetch, data and memory channels
//
//   Response FSM
//     state | meaning
//     IDLE  | no read response due this cycle
//     IRESP | fetch read returning: i_rvalid, i_rdata = m_rdata
//     DRESP | data read returning:  d_rvalid, d_rdata = m_rdata
module mem_arbiter #(
    parameter int Width     = 32,
    parameter int AddrWidth = 32,
    parameter int MAX_WAIT  = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IRESP = 2'd1,
        DRESP = 2'd2
    } respState_t;

    localparam logic [3:0] MaxWaitCnt = 4'(MAX_WAIT);

    respState_t       state;
    logic [3:0]       waitCnt;

    logic             dataWins;
    logic             iGnt;
    logic             dGnt;

    // Grants are combinational so a request can be served in the cycle it
    // appears; they are forced low while reset is held.
    always_comb begin
        dataWins = bus.d_req && (!bus.i_req || (waitCnt < MaxWaitCnt));
        dGnt     = reset && dataWins;
        iGnt     = reset && bus.i_req && !dataWins;
    end

    always_comb begin
        bus.i_gnt   = iGnt;
        bus.d_gnt   = dGnt;
        bus.m_en    = iGnt || dGnt;
        bus.m_we    = dGnt && bus.d_we;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        if (dGnt) begin
            bus.m_addr  = bus.d_addr;
            bus.m_wdata = bus.d_wdata;
        end else if (iGnt) begin
            bus.m_addr  = bus.i_addr;
        end
    end

    // Read data passes straight from memory; it is zeroed outside the
    // response cycle so the consumers never see stale or foreign data.
    always_comb begin
        bus.i_rvalid = (state == IRESP);
        bus.d_rvalid = (state == DRESP);
        bus.i_rdata  = bus.i_rvalid ? bus.m_rdata : '0;
        bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            if (iGnt) begin
                state <= IRESP;
            end else if (dGnt && !bus.d_we) begin
                state <= DRESP;
            end else begin
                state <= IDLE;
            end

            // Counts consecutive denied fetch cycles; a dropped or granted
            // fetch request restarts the count.
            if (bus.i_req && !iGnt) begin
                if (waitCnt < MaxWaitCnt) begin
                    waitCnt <= waitCnt + 4'd1;
                end
            end else begin
                waitCnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int Width     = 32;
    localparam int AddrWidth = 32;
    localparam int MaxWait   = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mem_arbiter_if #(.Width(Width), .AddrWidth(AddrWidth)) bus ();

    mem_arbiter #(.Width(Width), .AddrWidth(AddrWidth), .MAX_WAIT(MaxWait)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // ---------------- memory contents ----------------
    function automatic logic [Width-1:0] initWord(input logic [AddrWidth-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // tbMem: the memory the DUT actually talks to; refMem: the model's view.
    logic [Width-1:0] tbMem  [logic [AddrWidth-1:0]];
    logic [Width-1:0] refMem [logic [AddrWidth-1:0]];

    function automatic logic [Width-1:0] tbRead(input logic [AddrWidth-1:0] a);
        if (tbMem.exists(a)) return tbMem[a];
        return initWord(a);
    endfunction

    function automatic logic [Width-1:0] refRead(input logic [AddrWidth-1:0] a);
        if (refMem.exists(a)) return refMem[a];
        return initWord(a);
    endfunction

    // Memory responder: command observed mid-cycle, executed at the edge.
    logic                 opEn, opWe;
    logic [AddrWidth-1:0] opAddr;
    logic [Width-1:0]     opWdata;

    always @(negedge clk) begin
        opEn    = bus.m_en;
        opWe    = bus.m_we;
        opAddr  = bus.m_addr;
        opWdata = bus.m_wdata;
    end

    always @(posedge clk) begin
        if (opEn === 1'b1 && opWe === 1'b0) bus.m_rdata = tbRead(opAddr);
        else                                bus.m_rdata = $urandom;
        if (opEn === 1'b1 && opWe === 1'b1) tbMem[opAddr] = opWdata;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit               isData;
        logic [Width-1:0] data;
        int               due;
    } resp_t;

    resp_t expQ[$];
    int    waitCnt = 0;

    // Monitor: pops an expected response whenever the DUT presents one.
    always @(negedge clk) begin
        resp_t e;
        if (reset === 1'b1) begin
            while (expQ.size() > 0 && expQ[0].due < cycle) begin
                e = expQ.pop_front();
                check("response missing (due cycle)", 64'(cycle), 64'(e.due));
            end
            if (bus.i_rvalid === 1'b1 && bus.d_rvalid === 1'b1) begin
                check("both rvalid", 64'd1, 64'd0);
            end else if (bus.i_rvalid === 1'b1 || bus.d_rvalid === 1'b1) begin
                if (expQ.size() == 0) begin
                    check("unexpected rvalid", 64'd1, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    check("rvalid latency", 64'(cycle), 64'(e.due));
                    check("rvalid port is data", 64'(bus.d_rvalid), 64'(e.isData));
                    if (e.isData) check("d_rdata", 64'(bus.d_rdata), 64'(e.data));
                    else          check("i_rdata", 64'(bus.i_rdata), 64'(e.data));
                end
            end
            if (bus.i_rvalid !== 1'b1) check("i_rdata idle zero", 64'(bus.i_rdata), 64'd0);
            if (bus.d_rvalid !== 1'b1) check("d_rdata idle zero", 64'(bus.d_rdata), 64'd0);
        end
    end

    // One cycle: drive at posedge+1, check grants/command at negedge and
    // push the expected response derived from the arbitration rules.
    task automatic step(input logic ir, input logic [AddrWidth-1:0] ia,
                        input logic dr, input logic dw,
                        input logic [AddrWidth-1:0] da, input logic [Width-1:0] dd,
                        output logic expI, output logic expD);
        resp_t e;
        @(posedge clk); #1;
        bus.i_req   = ir;
        bus.i_addr  = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = dd;
        @(negedge clk);
        expD = dr && (!ir || waitCnt < MaxWait);
        expI = ir && !expD;
        check("i_gnt", 64'(bus.i_gnt), 64'(expI));
        check("d_gnt", 64'(bus.d_gnt), 64'(expD));
        check("m_en",  64'(bus.m_en),  64'(expI || expD));
        check("m_we",  64'(bus.m_we),  64'(expD && dw));
        check("m_addr", 64'(bus.m_addr), expD ? 64'(da) : (expI ? 64'(ia) : 64'd0));
        if (!expI) check("m_wdata", 64'(bus.m_wdata), expD ? 64'(dd) : 64'd0);
        if (expD) begin
            if (dw) refMem[da] = dd;
            else begin
                e.isData = 1'b1; e.data = refRead(da); e.due = cycle + 1;
                expQ.push_back(e);
            end
        end
        if (expI) begin
            e.isData = 1'b0; e.data = refRead(ia); e.due = cycle + 1;
            expQ.push_back(e);
        end
        if (ir && !expI) waitCnt = (waitCnt + 1 > MaxWait) ? MaxWait : waitCnt + 1;
        else             waitCnt = 0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " i_gnt"},    64'(bus.i_gnt),    64'd0);
        check({tag, " d_gnt"},    64'(bus.d_gnt),    64'd0);
        check({tag, " m_en"},     64'(bus.m_en),     64'd0);
        check({tag, " m_we"},     64'(bus.m_we),     64'd0);
        check({tag, " m_addr"},   64'(bus.m_addr),   64'd0);
        check({tag, " m_wdata"},  64'(bus.m_wdata),  64'd0);
        check({tag, " i_rvalid"}, 64'(bus.i_rvalid), 64'd0);
        check({tag, " d_rvalid"}, 64'(bus.d_rvalid), 64'd0);
        check({tag, " i_rdata"},  64'(bus.i_rdata),  64'd0);
        check({tag, " d_rdata"},  64'(bus.d_rdata),  64'd0);
    endtask

    // Reset asserted just after an edge, with requests active; any pending
    // response is discarded.
    task automatic doReset();
        @(posedge clk); #1;
        reset       = 1'b0;
        bus.i_req   = 1'b1; bus.i_addr = 32'h10;
        bus.d_req   = 1'b1; bus.d_we   = 1'b1;
        bus.d_addr  = 32'h40; bus.d_wdata = 32'hDEADBEEF;
        #1;
        checkAllZero("reset immediate");
        expQ.delete();
        waitCnt = 0;
        repeat (2) @(negedge clk);
        checkAllZero("reset held");
        @(posedge clk); #1;
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        reset     = 1'b1;
    endtask

    logic gi, gd;
    string pattern;

    initial begin
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.m_rdata = '0;
        opEn = 0; opWe = 0; opAddr = '0; opWdata = '0;
        doReset();

        // fetch only
        step(1, 32'h10, 0, 0, 0, 0, gi, gd);
        check("fetch m_addr 0x10", 64'(bus.m_addr), 64'h10);
        step(0, 0, 0, 0, 0, 0, gi, gd);
        check("fetch i_rvalid next", 64'(bus.i_rvalid), 64'd1);

        // simultaneous: data read wins
        step(1, 32'h20, 1, 0, 32'h200, 0, gi, gd);
        check("simul d_gnt", 64'(bus.d_gnt), 64'd1);
        step(1, 32'h20, 0, 0, 0, 0, gi, gd);
        check("simul d_rvalid", 64'(bus.d_rvalid), 64'd1);
        check("simul i_rvalid", 64'(bus.i_rvalid), 64'd0);
        step(0, 0, 0, 0, 0, 0, gi, gd);

        // starvation
        pattern = "";
        for (int k = 0; k < 6; k++) begin
            step(1, 32'h80, 1, 0, 32'(32'h300 + k * 4), 0, gi, gd);
            pattern = {pattern, bus.i_gnt ? "I" : (bus.d_gnt ? "D" : "-")};
        end
        compared++;
        if (pattern != "DDDDID") begin
            mismatched++;
            $display("FAIL starvation pattern: got %s, expected DDDDID", pattern);
        end
        step(0, 0, 0, 0, 0, 0, gi, gd);
        step(0, 0, 0, 0, 0, 0, gi, gd);

        // store, then read it back
        step(0, 0, 1, 1, 32'h40, 32'hDEADBEEF, gi, gd);
        check("store m_wdata", 64'(bus.m_wdata), 64'hDEADBEEF);
        step(0, 0, 1, 0, 32'h40, 0, gi, gd);
        check("store no d_rvalid", 64'(bus.d_rvalid), 64'd0);
        step(0, 0, 0, 0, 0, 0, gi, gd);
        check("store readback", 64'(bus.d_rdata), 64'hDEADBEEF);

        // back-to-back: data read then fetch
        step(0, 0, 1, 0, 32'h44, 0, gi, gd);
        step(1, 32'h14, 0, 0, 0, 0, gi, gd);
        check("b2b d_rvalid", 64'(bus.d_rvalid), 64'd1);
        check("b2b i_gnt", 64'(bus.i_gnt), 64'd1);
        step(0, 0, 0, 0, 0, 0, gi, gd);
        check("b2b i_rvalid", 64'(bus.i_rvalid), 64'd1);

        // reset right after a fetch grant
        step(1, 32'h18, 0, 0, 0, 0, gi, gd);
        doReset();
        step(1, 32'h1C, 1, 0, 32'h48, 0, gi, gd);
        check("post-reset i_rvalid", 64'(bus.i_rvalid), 64'd0);
        check("post-reset d_gnt", 64'(bus.d_gnt), 64'd1);

        // randomized traffic honouring the hold-until-grant protocol
        begin
            logic iPend = 0, dPend = 0, dw = 0;
            logic [AddrWidth-1:0] ia = '0, da = '0;
            logic [Width-1:0] dd = '0;
            for (int n = 0; n < 600; n++) begin
                if (!iPend || $urandom_range(0, 15) == 0) begin
                    iPend = ($urandom_range(0, 2) != 0);
                    ia    = 32'($urandom_range(0, 31) * 4);
                end
                if (!dPend || $urandom_range(0, 15) == 0) begin
                    dPend = ($urandom_range(0, 2) != 0);
                    dw    = $urandom_range(0, 1) == 1;
                    da    = 32'($urandom_range(0, 31) * 4);
                    dd    = $urandom;
                end
                if (n == 300) doReset();
                step(iPend, ia, dPend, dw, da, dd, gi, gd);
                if (gi) iPend = 0;
                if (gd) dPend = 0;
            end
        end

        step(0, 0, 0, 0, 0, 0, gi, gd);
        step(0, 0, 0, 0, 0, 0, gi, gd);
        check("scoreboard drained", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter Width, default 32: data bus width in bits.
REQ-002 Parameter AddrWidth, default 32: byte address width.
REQ-003 Parameter MAX_WAIT, default 4: consecutive denied fetch cycles before fetch gets forced priority; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset: asserted when low, takes effect immediately, released synchronously to clk.
REQ-006 i_req  input  1  fetch read request; held with i_addr stable until i_gnt.
REQ-007 i_addr  input  AddrWidth  fetch address (pcF).
REQ-008 i_gnt  output  1  fetch request accepted this cycle.
REQ-009 i_rvalid  output  1  fetch read data valid this cycle.
REQ-010 i_rdata  output  Width  fetch read data (InstrF); meaningful only with i_rvalid.
REQ-011 d_req  input  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt.
REQ-012 d_we  input  1  1 = write, 0 = read.
REQ-013 d_addr  input  AddrWidth  data address (ALUResultM).
REQ-014 d_wdata  input  Width  store data (WriteDataM).
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  data read data valid this cycle (never for writes).
REQ-017 d_rdata  output  Width  data read data (ReadDataM); meaningful only with d_rvalid.
REQ-018 m_en, m_we  output  1 each  single-port unified memory enable and write enable.
REQ-019 m_addr, m_wdata  output  AddrWidth, Width  memory address and write data.
REQ-020 m_rdata  input  Width  memory read data, valid one cycle after a read enable.

Function
REQ-021 At most one memory access SHALL be issued per cycle; grants, m_en, m_we, m_addr, m_wdata combinational from same-cycle requests and registered state.
REQ-022 Grant rule: d_req and (not i_req or wait_cnt < MAX_WAIT) -> data granted; else i_req -> fetch granted; else neither; i_gnt and d_gnt never both 1.
REQ-023 Granted cycle: m_en=1, m_addr = winner address; m_we = d_we and m_wdata = d_wdata for data grant, m_we=0 for fetch grant; idle cycle: m_en=0, m_we=0, m_addr=0, m_wdata=0.
REQ-024 Response FSM states IDLE, IRESP, DRESP; next state = IRESP after fetch grant, DRESP after data read grant, IDLE otherwise (including data write grant).
REQ-025 In IRESP: i_rvalid=1, i_rdata=m_rdata; in DRESP: d_rvalid=1, d_rdata=m_rdata; rvalid outputs 0 and rdata outputs 0 otherwise.
REQ-026 A new grant SHALL be allowed in the same cycle a response is delivered (back-to-back, one access per cycle throughput); read latency exactly 1 cycle grant-to-rvalid.
REQ-027 wait_cnt (4-bit): +1 when i_req and not i_gnt, saturating at MAX_WAIT; cleared to 0 when i_gnt or not i_req.
REQ-028 Write grant SHALL NOT produce any rvalid.
REQ-029 Request dropped without grant: no access, no state change other than wait_cnt rule.

Reset
REQ-030 While reset low: state IDLE, wait_cnt 0, i_gnt=d_gnt=0, m_en=m_we=0, i_rvalid=d_rvalid=0, all data/address outputs 0.
REQ-031 Reset asserted with a read pending: response discarded; no rvalid in the first cycle after release.
REQ-032 First cycle after release: grants follow REQ-022 with wait_cnt 0.

Verification
REQ-033 Fetch only: i_req=1, i_addr=0x10 -> i_gnt=1, m_en=1, m_addr=0x10 same cycle; next cycle i_rvalid=1, i_rdata=m_rdata.
REQ-034 Simultaneous: i_req=1, d_req=1 read d_addr=0x200 -> d_gnt=1, i_gnt=0; next cycle d_rvalid=1, i_rvalid=0.
REQ-035 Starvation: d_req and i_req held 1 for 6 cycles, MAX_WAIT=4 -> d_gnt cycles 1-4, i_gnt cycle 5, d_gnt cycle 6; wait_cnt 0 after cycle 5.
REQ-036 Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> m_we=1, m_wdata=0xDEADBEEF same cycle; no d_rvalid next cycle.
REQ-037 Back-to-back: data read then fetch in consecutive cycles -> d_rvalid and i_gnt in same cycle, i_rvalid following cycle.
REQ-038 Reset low the cycle after a fetch grant -> i_rvalid=0 immediately and after release; all outputs 0 during reset.
